// File: rtl/fan_timer_pkg.sv
// Shared state encodings and speed limits for the fan/timer control unit.
package fan_timer_pkg;

  typedef enum logic {
    S_FAN_OFF = 1'b0,
    S_FAN_ON  = 1'b1
  } fan_state_e;

  typedef enum logic {
    S_TIMER_OFF = 1'b0,
    S_TIMER_ON  = 1'b1
  } timer_state_e;

  localparam logic [3:0] SPEED_MIN = 4'd1;
  localparam logic [3:0] SPEED_MAX = 4'd3;

  function automatic logic [3:0] next_speed(input logic [3:0] s);
    return (s >= SPEED_MAX) ? SPEED_MIN : s + 4'd1;
  endfunction

endpackage

// File: rtl/fan_timer_fsm_sec_prescaler.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled, ticks at terminal count.
module sec_prescaler #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = $clog2(CLK_HZ);
  localparam logic [W-1:0] TC = W'(CLK_HZ - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Tick must not depend on clr_i: the parent derives clr_i from expiry.
  assign tick_o = en_i && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == TC) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fan_timer_fsm.sv
// Fan/timer control FSM with shutdown countdown.
// FAN_TIMER_BTN_EDGE_EN: treat buttons as held levels and act on rising edges.
module fan_timer_fsm
  import fan_timer_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TIMER_STEP_S    = 60,
  parameter int TIMER_MAX_STEPS = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_btn_power,
  input  logic        i_btn_speed,
  input  logic        i_btn_timer,
  output logic        o_FANOnOff,
  output logic        o_TIMEROnOff,
  output logic [3:0]  o_speed,
  output logic [15:0] o_timer_remaining
);

  localparam logic [2:0]  K_MAX = 3'(TIMER_MAX_STEPS);
  localparam logic [15:0] STEP  = 16'(TIMER_STEP_S);

  fan_state_e   fan_q, fan_d;
  timer_state_e tmr_q, tmr_d;
  logic [3:0]   spd_q, spd_d;
  logic [3:0]   spd_o_q, spd_o_d;
  logic [2:0]   k_q, k_d;
  logic [15:0]  rem_q, rem_d;
  logic         pwr_ev, spd_ev, tmr_ev;
  logic         tick, clr, expire;

`ifdef FAN_TIMER_BTN_EDGE_EN
  logic [2:0] btn_q, btn_p_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      btn_q   <= '0;
      btn_p_q <= '0;
    end else begin
      btn_q   <= {i_btn_power, i_btn_speed, i_btn_timer};
      btn_p_q <= btn_q;
    end
  end

  assign {pwr_ev, spd_ev, tmr_ev} = btn_q & ~btn_p_q;
`else
  assign {pwr_ev, spd_ev, tmr_ev} = {i_btn_power, i_btn_speed, i_btn_timer};
`endif

  sec_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_presc (
    .clk_i  (i_clk),
    .rst_i  (i_reset),
    .clr_i  (clr),
    .en_i   (tmr_q == S_TIMER_ON),
    .tick_o (tick)
  );

  assign expire = tick && (rem_q == 16'd1);

  always_comb begin
    fan_d  = fan_q;
    tmr_d  = tmr_q;
    spd_d  = spd_q;
    k_d    = k_q;
    rem_d  = rem_q;
    clr    = 1'b0;
    if (pwr_ev && fan_q == S_FAN_OFF) begin
      fan_d = S_FAN_ON;
      spd_d = SPEED_MIN;
    end else if (pwr_ev || (fan_q == S_FAN_ON && expire)) begin
      fan_d = S_FAN_OFF;
      tmr_d = S_TIMER_OFF;
      k_d   = '0;
      rem_d = '0;
      clr   = 1'b1;
    end else if (fan_q == S_FAN_ON) begin
      if (spd_ev) spd_d = next_speed(spd_q);
      // A preset reload on a tick cycle swallows that cycle's decrement.
      if (tmr_ev) begin
        clr = 1'b1;
        if (k_q >= K_MAX) begin
          k_d   = '0;
          tmr_d = S_TIMER_OFF;
          rem_d = '0;
        end else begin
          k_d   = k_q + 3'd1;
          tmr_d = S_TIMER_ON;
          rem_d = STEP * {13'd0, k_q + 3'd1};
        end
      end else if (tick && rem_q != '0) begin
        rem_d = rem_q - 16'd1;
      end
    end
    spd_o_d = (fan_d == S_FAN_ON) ? spd_d : 4'd0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fan_q   <= S_FAN_OFF;
      tmr_q   <= S_TIMER_OFF;
      spd_q   <= SPEED_MIN;
      spd_o_q <= '0;
      k_q     <= '0;
      rem_q   <= '0;
    end else begin
      fan_q   <= fan_d;
      tmr_q   <= tmr_d;
      spd_q   <= spd_d;
      spd_o_q <= spd_o_d;
      k_q     <= k_d;
      rem_q   <= rem_d;
    end
  end

  assign o_FANOnOff        = (fan_q == S_FAN_ON);
  assign o_TIMEROnOff      = (tmr_q == S_TIMER_ON);
  assign o_speed           = spd_o_q;
  assign o_timer_remaining = rem_q;

endmodule

// File: tb/tb_fan_timer_fsm.sv
// Self-checking bench for fan_timer_fsm with a cycle-count reference model.
module tb_fan_timer_fsm;

  localparam int HZ   = 10;
  localparam int STEP = 2;
  localparam int KMAX = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        b_pwr = 1'b0;
  logic        b_spd = 1'b0;
  logic        b_tmr = 1'b0;
  logic        fan_o, tmr_o;
  logic [3:0]  spd_o;
  logic [15:0] rem_o;

  int vecs = 0;
  int errs = 0;

  // Model: timer value derived from cycles elapsed since the preset edge.
  int m_fan, m_spd, m_k, m_el;

  fan_timer_fsm #(
    .CLK_HZ          (HZ),
    .TIMER_STEP_S    (STEP),
    .TIMER_MAX_STEPS (KMAX)
  ) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_btn_power       (b_pwr),
    .i_btn_speed       (b_spd),
    .i_btn_timer       (b_tmr),
    .o_FANOnOff        (fan_o),
    .o_TIMEROnOff      (tmr_o),
    .o_speed           (spd_o),
    .o_timer_remaining (rem_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_fan = 0; m_spd = 1; m_k = 0; m_el = 0;
  endtask

  task automatic model_update(input bit p, input bit s, input bit t);
    if (p) begin
      if (m_fan == 0) begin
        m_fan = 1; m_spd = 1;
      end else begin
        m_fan = 0; m_k = 0; m_el = 0;
      end
    end else if (m_fan == 1) begin
      if (m_k > 0 && m_el + 1 == m_k * STEP * HZ) begin
        m_fan = 0; m_k = 0; m_el = 0;
      end else begin
        if (s) m_spd = (m_spd % 3) + 1;
        if (t) begin
          m_k = (m_k + 1) % (KMAX + 1);
          m_el = 0;
        end else if (m_k > 0) begin
          m_el++;
        end
      end
    end
  endtask

  function automatic logic [21:0] model_out();
    int r;
    r = (m_k > 0) ? m_k * STEP - m_el / HZ : 0;
    return {m_fan[0], (m_k > 0), (m_fan != 0) ? 4'(m_spd) : 4'd0, 16'(r)};
  endfunction

  task automatic step(input bit p, input bit s, input bit t);
    b_pwr = p; b_spd = s; b_tmr = t;
    model_update(p, s, t);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b_pwr = 0; b_spd = 0; b_tmr = 0;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if ({fan_o, tmr_o, spd_o, rem_o} !== 22'd0) begin
      errs++;
      $display("FAIL reset: got %h want 0", {fan_o, tmr_o, spd_o, rem_o});
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_power_speed();
    logic [3:0] want [4];
    want = '{4'd2, 4'd3, 4'd1, 4'd2};
    step(1, 0, 0);
    vecs++;
    if (fan_o !== 1'b1 || spd_o !== 4'd1 || tmr_o !== 1'b0) begin
      errs++;
      $display("FAIL power_on: fan=%b spd=%0d tmr=%b want 1 1 0", fan_o, spd_o, tmr_o);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0);
      vecs++;
      if (spd_o !== want[i]) begin
        errs++;
        $display("FAIL speed_step%0d: got %0d want %0d", i, spd_o, want[i]);
      end
    end
    step(1, 0, 0);
  endtask

  task automatic test_countdown();
    step(1, 0, 0);
    step(0, 0, 1);
    vecs++;
    if (tmr_o !== 1'b1 || rem_o !== 16'd2) begin
      errs++;
      $display("FAIL timer_set: tmr=%b rem=%0d want 1 2", tmr_o, rem_o);
    end
    for (int c = 1; c <= 20; c++) begin
      step(0, 0, 0);
      if (c == 9 || c == 10 || c == 19) begin
        vecs++;
        if (fan_o !== 1'b1 || rem_o !== ((c < 10) ? 16'd2 : 16'd1)) begin
          errs++;
          $display("FAIL countdown_c%0d: fan=%b rem=%0d", c, fan_o, rem_o);
        end
      end
    end
    vecs++;
    if ({fan_o, tmr_o, spd_o, rem_o} !== 22'd0) begin
      errs++;
      $display("FAIL expiry: got %h want 0", {fan_o, tmr_o, spd_o, rem_o});
    end
  endtask

  task automatic test_presets();
    logic [15:0] want [4];
    want = '{16'd2, 16'd4, 16'd6, 16'd0};
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1);
      vecs++;
      if (rem_o !== want[i] || tmr_o !== (i < 3)) begin
        errs++;
        $display("FAIL preset%0d: rem=%0d tmr=%b want %0d", i, rem_o, tmr_o, want[i]);
      end
    end
    step(1, 0, 0);
  endtask

  task automatic test_fan_off_ignore();
    step(0, 1, 0);
    step(0, 0, 1);
    step(0, 1, 1);
    vecs++;
    if ({fan_o, tmr_o, spd_o, rem_o} !== 22'd0) begin
      errs++;
      $display("FAIL off_ignore: got %h want 0", {fan_o, tmr_o, spd_o, rem_o});
    end
    step(1, 1, 0);
    vecs++;
    if (fan_o !== 1'b1 || spd_o !== 4'd1) begin
      errs++;
      $display("FAIL pwr_spd_same: fan=%b spd=%0d want 1 1", fan_o, spd_o);
    end
    step(1, 0, 0);
  endtask

  task automatic test_reset_midcount();
    step(1, 0, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    for (int c = 0; c < 15; c++) step(0, 0, 0);
    vecs++;
    if (rem_o !== 16'd3 || fan_o !== 1'b1) begin
      errs++;
      $display("FAIL pre_reset: rem=%0d fan=%b want 3 1", rem_o, fan_o);
    end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if ({fan_o, tmr_o, spd_o, rem_o} !== 22'd0) begin
      errs++;
      $display("FAIL async_reset: got %h want 0", {fan_o, tmr_o, spd_o, rem_o});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int c = 0; c < 60; c++) begin
      step(0, 0, 0);
      vecs++;
      if ({fan_o, tmr_o, spd_o, rem_o} !== 22'd0) begin
        errs++;
        $display("FAIL post_reset_c%0d: got %h want 0", c, {fan_o, tmr_o, spd_o, rem_o});
      end
    end
  endtask

  task automatic test_random();
    bit p, s, t;
    logic [21:0] exp_v;
    for (int c = 0; c < 3000; c++) begin
      p = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 5) == 0);
      t = ($urandom_range(0, 49) == 0);
      step(p, s, t);
      exp_v = model_out();
      vecs++;
      if ({fan_o, tmr_o, spd_o, rem_o} !== exp_v) begin
        errs++;
        $display("FAIL random_c%0d: got %h want %h", c, {fan_o, tmr_o, spd_o, rem_o}, exp_v);
      end
    end
  endtask

  task automatic test_edge_hold();
    step(1, 0, 0);
    step(0, 0, 0);
    vecs++;
    if (fan_o !== 1'b1 || spd_o !== 4'd1) begin
      errs++;
      $display("FAIL edge_power: fan=%b spd=%0d want 1 1", fan_o, spd_o);
    end
    step(0, 1, 0);
    vecs++;
    if (spd_o !== 4'd1) begin
      errs++;
      $display("FAIL edge_lat1: spd=%0d want 1", spd_o);
    end
    for (int c = 1; c < 30; c++) begin
      step(0, 1, 0);
      vecs++;
      if (spd_o !== 4'd2) begin
        errs++;
        $display("FAIL edge_hold_c%0d: spd=%0d want 2", c, spd_o);
      end
    end
    step(0, 0, 0);
    step(0, 0, 0);
    vecs++;
    if (spd_o !== 4'd2) begin
      errs++;
      $display("FAIL edge_release: spd=%0d want 2", spd_o);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
`ifdef FAN_TIMER_BTN_EDGE_EN
    test_edge_hold();
`else
    test_power_speed();
    test_countdown();
    test_presets();
    test_fan_off_ignore();
    test_reset_midcount();
    test_reset();
    test_random();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
